hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_W, default 5: register-address width; register file holds 2**REG_W entries.
REQ-002 SHALL have parameter MAX_PENDING, default 4: maximum in-flight long-latency writes; power of two, >=2.
REQ-003 SHALL have port clock, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port issue_valid, input, 1: an instruction leaves decode this cycle.
REQ-006 SHALL have port issue_long, input, 1: the issuing instruction is long-latency (mult/div) and writes issue_rd.
REQ-007 SHALL have port issue_rd, input, REG_W: destination register of the issuing instruction.
REQ-008 SHALL have ports src_a and src_b, input, REG_W each: source registers read by the decoding instruction.
REQ-009 SHALL have ports use_a and use_b, input, 1 each: the corresponding source is actually read.
REQ-010 SHALL have port complete_valid, input, 1: the long-latency unit retires its oldest result this cycle.
REQ-011 SHALL have port stall, output, 1: hold fetch/decode and insert a bubble.
REQ-012 SHALL have port complete_rd, output, REG_W: destination of the oldest pending entry (write-back register select).
REQ-013 SHALL have port fwd_a and fwd_b, output, 1 each: take the operand from the completing result.
REQ-014 SHALL have ports count (output, clog2(MAX_PENDING)+1 bits), full (output, 1) and empty (output, 1).
REQ-015 SHALL have port err, output, 1: sticky protocol error.

Function
REQ-016 SHALL keep a busy bit per register and an in-order FIFO of pending destination tags, MAX_PENDING deep.
REQ-017 SHALL never set busy for register 0; a long issue to r0 SHALL still occupy a FIFO slot.
REQ-018 SHALL drive stall combinationally when: (use_a and busy[src_a] and no forward), or (use_b and busy[src_b] and no forward), or (issue_long and full and not complete_valid), or (issue_long and issue_rd != 0 and busy[issue_rd]) (WAW).
REQ-019 SHALL accept an issue only when issue_valid and not stall; an issue during stall SHALL change no state.
REQ-020 SHALL, on an accepted long issue, push issue_rd, set busy[issue_rd], and increment count, effective the next cycle.
REQ-021 SHALL, on complete_valid with empty deasserted, pop the head, clear busy[head] and decrement count, effective the next cycle.
REQ-022 SHALL, on simultaneous accepted push and pop, leave count unchanged and keep the FIFO order correct, including when full.
REQ-023 SHALL ignore complete_valid while empty and set err; err SHALL hold until reset.
REQ-024 SHALL drive complete_rd = FIFO head; when empty, complete_rd SHALL be 0.
REQ-025 SHALL wrap the FIFO read and write pointers modulo MAX_PENDING.
REQ-026 SHALL keep full = (count == MAX_PENDING) and empty = (count == 0).

Reset
REQ-027 SHALL, on reset high at a rising edge, clear all busy bits, both pointers, count and err; full=0, empty=1, complete_rd=0.
REQ-028 SHALL give reset priority over a simultaneous issue or completion; entries in flight at reset SHALL be discarded.

Configuration
REQ-029 SHALL recognise macro SCOREBOARD_FWD_EN.
REQ-030 SHALL, with SCOREBOARD_FWD_EN defined, assert fwd_a when use_a, complete_valid, not empty and src_a == complete_rd != 0; fwd_b likewise. A forwarded source SHALL not cause a stall.
REQ-031 SHALL, without SCOREBOARD_FWD_EN, tie fwd_a and fwd_b to 0; a source matching the completing register SHALL stall for that cycle and release the next cycle.

Verification
REQ-032 SHALL cover: long issue r5, next cycle src_a=5 use_a=1 -> stall=1 until the cycle after complete_valid; count 1->0.
REQ-033 SHALL cover: 4 long issues r1..r4 (MAX_PENDING=4), then a 5th long issue -> full=1, stall=1, count=4; with complete_valid in the same cycle -> issue accepted, count stays 4, complete_rd=1.
REQ-034 SHALL cover: complete_valid while empty -> err=1, count=0, remains 1 until reset.
REQ-035 SHALL cover: long issue r0 -> count=1, no busy bit; src_a=0 use_a=1 -> stall=0.
REQ-036 SHALL cover: pending r7, src_b=7 use_b=1, complete_valid -> with SCOREBOARD_FWD_EN: fwd_b=1, stall=0; without: fwd_b=0, stall=1.
REQ-037 SHALL cover: 2 pending entries, reset asserted together with issue_valid -> next cycle count=0, empty=1, all busy clear.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Purpose : register hazard scoreboard for long-latency (mult/div) writes; busy bit per
//           register plus an in-order FIFO of pending destination tags.
// Latency : stall/fwd/complete_rd are combinational; busy/count/err update on the next edge.
// Backpressure: stall holds decode on RAW, WAW or full-FIFO hazards; a stalled issue changes no state.
//
// Ports:
//   clock, reset                : single clock, synchronous active-high reset
//   issue_valid/issue_long/issue_rd : instruction leaving decode, long-latency flag, destination
//   src_a/src_b, use_a/use_b    : source registers of the decoding instruction and their use flags
//   complete_valid              : long-latency unit retires its oldest result this cycle
//   stall                       : hold fetch/decode, insert bubble
//   complete_rd                 : destination of the oldest pending entry (0 when empty)
//   fwd_a/fwd_b                 : take operand from the completing result
//   count/full/empty            : FIFO occupancy
//   err                         : sticky flag, completion seen while nothing pending
//
// Optional feature macro: SCOREBOARD_FWD_EN (completion-to-decode forwarding).

// Generic FIFO: accepts a push while full if a pop happens in the same cycle.
// Latency: push visible at the head one cycle later; head is a combinational read.
// Backpressure: pushes while full (without pop) and pops while empty are dropped.
module fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module hazard_scoreboard #(
  parameter int REG_W       = 5,
  parameter int MAX_PENDING = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           issue_valid,
  input  logic                           issue_long,
  input  logic [REG_W-1:0]               issue_rd,
  input  logic [REG_W-1:0]               src_a,
  input  logic [REG_W-1:0]               src_b,
  input  logic                           use_a,
  input  logic                           use_b,
  input  logic                           complete_valid,
  output logic                           stall,
  output logic [REG_W-1:0]               complete_rd,
  output logic                           fwd_a,
  output logic                           fwd_b,
  output logic [$clog2(MAX_PENDING):0]   count,
  output logic                           full,
  output logic                           empty,
  output logic                           err
);
  localparam int NREG = 2**REG_W;

  logic [NREG-1:0]  busy;
  logic [REG_W-1:0] head;
  logic             accept;
  logic             push;
  logic             pop;
  logic             raw_a;
  logic             raw_b;
  logic             full_hz;
  logic             waw_hz;

  fifo #(
    .W     (REG_W),
    .DEPTH (MAX_PENDING)
  ) u_tags (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (issue_rd),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign complete_rd = empty ? '0 : head;

`ifdef SCOREBOARD_FWD_EN
  // r0 is never tracked, so a completing r0 never forwards.
  assign fwd_a = use_a && complete_valid && !empty &&
                 (src_a == complete_rd) && (complete_rd != '0);
  assign fwd_b = use_b && complete_valid && !empty &&
                 (src_b == complete_rd) && (complete_rd != '0);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // busy[0] is never set, so reads of r0 never raise a RAW hazard.
  assign raw_a   = use_a && busy[src_a] && !fwd_a;
  assign raw_b   = use_b && busy[src_b] && !fwd_b;
  // A full FIFO still takes a new tag when the head retires in the same cycle.
  assign full_hz = issue_long && full && !complete_valid;
  assign waw_hz  = issue_long && (issue_rd != '0) && busy[issue_rd];
  assign stall   = raw_a || raw_b || full_hz || waw_hz;

  assign accept = issue_valid && !stall;
  assign push   = accept && issue_long;
  assign pop    = complete_valid && !empty;

  // Clear for the retiring head first so a same-cycle set wins; the WAW check
  // keeps a live tag from being pushed again, so the two never collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (pop && (head != '0))      busy[head]     <= 1'b0;
      if (push && (issue_rd != '0)) busy[issue_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (complete_valid && empty) begin
      err <= 1'b1;
    end
  end
endmodule
